uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter HDR_EN, default 1, meaning a source-ID header byte is prepended to each packet.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles forced after each packet (0..255).
REQ-003 SHALL have parameter MAX_LEN, default 256, meaning the maximum number of payload bytes per grant (1..256).
REQ-004 sys_clk  input  1  single clock; all state is on the rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 s0_data  input  8  source 0 byte; s0_valid input 1; s0_last input 1, marking the final byte of a packet; s0_ready output 1.
REQ-007 s1_data  input  8; s1_valid input 1; s1_last input 1; s1_ready output 1; these have the same meanings as for source 0.
REQ-008 tx_data  output  8  byte to the UART transmitter; tx_valid output 1; tx_ready input 1, asserted when the transmitter accepts.
REQ-009 grant  output  2  one-hot current owner (01=s0, 10=s1, 00=none).
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 trunc  output  1  one-cycle pulse when a packet is cut at MAX_LEN.

Function
REQ-012 A byte SHALL transfer on any edge where valid and ready are both high; this rule applies on both sides.
REQ-013 The FSM SHALL have exactly four states: IDLE, HDR, DATA and GAP.
REQ-014 In IDLE with any s*_valid high, the block SHALL register the owner and leave next edge; target is HDR if HDR_EN=1, else DATA.
REQ-015 Arbitration SHALL be round-robin via a 1-bit pointer prio: if only one source is valid, it wins; if both are valid, source prio wins.
REQ-016 prio SHALL be set to the non-winning source at each grant.
REQ-017 In HDR, the block SHALL drive tx_valid=1 and tx_data=8'hA0 | owner_id (0xA0 or 0xA1), held stable until accepted, then go to DATA.
REQ-018 In HDR, the block SHALL hold s0_ready=s1_ready=0.
REQ-019 In DATA, tx_data and tx_valid SHALL be combinational copies of the owner's data/valid, and the owner's ready SHALL equal tx_ready.
REQ-020 In DATA, the non-owner's ready SHALL be 0.
REQ-021 A 9-bit payload counter SHALL clear on grant and increment on each DATA transfer.
REQ-022 DATA SHALL exit on a transfer with owner last=1, or on the transfer that makes the count equal MAX_LEN.
REQ-023 If DATA exits at MAX_LEN with last=0, trunc SHALL pulse on the cycle after that transfer.
REQ-024 On DATA exit, the next state SHALL be GAP if GAP_CYCLES>0, else IDLE.
REQ-025 If last and the MAX_LEN hit occur on the same transfer, the packet SHALL be treated as normal, with no trunc pulse.
REQ-026 In GAP, tx_valid SHALL be 0 and all s*_ready 0; an 8-bit counter SHALL run GAP_CYCLES cycles, then the FSM returns to IDLE.
REQ-027 grant SHALL be held from the cycle after the IDLE decision through the end of GAP.
REQ-028 In IDLE, tx_valid, grant and all s*_ready SHALL be 0, and tx_data SHALL be 0.
REQ-029 Source valid deasserting in DATA SHALL stall the packet without losing ownership; the block SHALL have no timeout.
REQ-030 Best-case throughput SHALL be one byte per cycle in HDR/DATA; IDLE-to-first-tx_valid latency SHALL be 1 cycle.

Reset
REQ-031 On sys_rst_n low, the block SHALL immediately enter IDLE and clear prio, owner, both counters, grant, busy, trunc, tx_valid and all s*_ready.
REQ-032 This reset behaviour SHALL apply regardless of state, including mid-packet, which is aborted.
REQ-033 After release, the first simultaneous request SHALL be granted to s0.

Verification
REQ-034 Defaults, tx_ready=1, s0 sends 0x11,0x22,0x33(last=1 on 0x33): tx sees 0xA0,0x11,0x22,0x33 on consecutive cycles, grant=01, then tx_valid=0 for 16 cycles, then busy=0.
REQ-035 Both sources valid in the same cycle after reset, one byte each with last: order is 0xA0,s0 byte,gap,0xA1,s1 byte; a repeat of the same stimulus gives s0 first again.
REQ-036 tx_ready toggled 1010...: 0xA0 is held stable until accepted, s0_ready mirrors tx_ready only in DATA, no byte is duplicated or dropped.
REQ-037 MAX_LEN=4, s1 sends 6 bytes with last only on byte 6: 0xA1+4 bytes, trunc pulses once, gap, 0xA1+2 bytes, no trunc.
REQ-038 sys_rst_n pulsed low mid-DATA: tx_valid, grant, busy and s*_ready go to 0 without waiting for a clock edge; after release the next dual request is granted to s0.
REQ-039 HDR_EN=0, GAP_CYCLES=0, back-to-back s0 packets: pure pass-through with one IDLE cycle between packets, no header bytes.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter, two byte sources into one UART tx.
// Ports: sys_clk/sys_rst_n; s0_*/s1_* sources; tx_* sink; grant, busy, trunc status.
module uart_tx_arbiter #(
  parameter int HDR_EN     = 1,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_LEN    = 256
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       trunc
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    GAP
  } state_t;

  localparam logic [8:0] LenMax = 9'(MAX_LEN);
  localparam logic [7:0] GapEnd =
    8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam state_t FirstSt =
    (HDR_EN != 0) ? HDR : DATA;
  localparam state_t EndSt =
    (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       owner_q, owner_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] gap_q, gap_d;
  logic       trunc_q, trunc_d;

  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       win;
  logic       xfer;
  logic       hit;
  logic [8:0] cnt_inc;

  assign own_valid = owner_q ? s1_valid : s0_valid;
  assign own_last  = owner_q ? s1_last  : s0_last;
  assign own_data  = owner_q ? s1_data  : s0_data;

  // both requesting: prio names the winner
  assign win = (s0_valid & s1_valid) ? prio_q
                                     : s1_valid;

  assign xfer    = own_valid & tx_ready;
  assign cnt_inc = cnt_q + 9'd1;
  assign hit     = (cnt_inc == LenMax);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= 9'd0;
      gap_q   <= 8'd0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    trunc_d  = 1'b0;
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_valid | s1_valid) begin
          owner_d = win;
          prio_d  = ~win;
          cnt_d   = 9'd0;
          gap_d   = 8'd0;
          state_d = FirstSt;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = {7'b1010000, owner_q};
        if (tx_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx_valid = own_valid;
        tx_data  = own_data;
        s0_ready = ~owner_q & tx_ready;
        s1_ready = owner_q & tx_ready;
        if (xfer) begin
          cnt_d = cnt_inc;
          if (own_last | hit) begin
            // a last byte landing on the limit is a normal end
            trunc_d = hit & ~own_last;
            gap_d   = 8'd0;
            state_d = EndSt;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GapEnd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign grant = busy ? {owner_q, ~owner_q} : 2'b00;
  assign trunc = trunc_q;

endmodule
